dm_port_arbiter: RTL



---
 rtl/dm_port_arbiter_if.sv | 36 +++
 rtl/dm_port_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/dm_port_arbiter_if.sv
// Signal bundle between the two data-memory masters, the port arbiter and the RAM.
// The arbiter takes the slave view; whoever stands in for the masters and RAM takes the master view.
interface dm_port_arbiter_if;
   logic        req0;
   logic        req1;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic [3:0]  byteen0;
   logic [3:0]  byteen1;
   logic        gnt0;
   logic        gnt1;
   logic        rvalid0;
   logic        rvalid1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;
   logic        stall0;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_rdata;

   modport slave (
      input  req0, req1, addr0, addr1, wdata0, wdata1, byteen0, byteen1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, stall0,
             mem_en, mem_addr, mem_wdata, mem_byteen
   );

   modport master (
      output req0, req1, addr0, addr1, wdata0, wdata1, byteen0, byteen1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, stall0,
             mem_en, mem_addr, mem_wdata, mem_byteen
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single data-memory port (1-cycle read latency RAM).
// Define DM_ARB_RR_EN for round-robin; default is port-0 priority with port-1 starvation override.
module dm_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int WAIT_W       = 3
) (
   input logic              clk,
   input logic              reset,
   dm_port_arbiter_if.slave bus
);

   logic gnt0;
   logic gnt1;
   logic mem_en;
   logic resp_v_q;
   logic resp_v_d;
   logic resp_id_q;
   logic resp_id_d;

`ifdef DM_ARB_RR_EN
   logic last_grant_q;
   logic last_grant_d;
`else
   localparam logic [WAIT_W-1:0] STARVE_CNT = WAIT_W'(STARVE_LIMIT);

   logic [WAIT_W-1:0] wait_cnt_q;
   logic [WAIT_W-1:0] wait_cnt_d;
   logic              starve;

   assign starve = (wait_cnt_q == STARVE_CNT);
`endif

   always_comb begin
      // NOTE: both grants get a default first so no path leaves them unassigned (no latch).
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (bus.req0 && bus.req1) begin
`ifdef DM_ARB_RR_EN
         gnt0 = last_grant_q;
`else
         gnt0 = ~starve;
`endif
         gnt1 = ~gnt0;
      end else begin
         gnt0 = bus.req0;
         gnt1 = bus.req1;
      end
   end

   assign mem_en = gnt0 | gnt1;

   always_comb begin
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.mem_byteen = '0;
      if (gnt1) begin
         bus.mem_addr   = bus.addr1;
         bus.mem_wdata  = bus.wdata1;
         bus.mem_byteen = bus.byteen1;
      end else if (gnt0) begin
         bus.mem_addr   = bus.addr0;
         bus.mem_wdata  = bus.wdata0;
         bus.mem_byteen = bus.byteen0;
      end
   end

   // Every issued access, read or write, owes its master exactly one completion next cycle.
   always_comb begin
      resp_v_d  = mem_en;
      resp_id_d = gnt1;
   end

`ifdef DM_ARB_RR_EN
   always_comb begin
      last_grant_d = last_grant_q;
      if (mem_en) last_grant_d = gnt1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end
`else
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!bus.req1 || gnt1) wait_cnt_d = '0;
      else if (!starve)      wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wait_cnt_q <= '0;
      else       wait_cnt_q <= wait_cnt_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_v_q  <= 1'b0;
         resp_id_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         resp_v_q  <= resp_v_d;
         resp_id_q <= resp_id_d;
      end
   end

   assign bus.gnt0    = gnt0;
   assign bus.gnt1    = gnt1;
   assign bus.mem_en  = mem_en;
   assign bus.stall0  = bus.req0 & ~gnt0;
   assign bus.rvalid0 = resp_v_q & ~resp_id_q;
   assign bus.rvalid1 = resp_v_q & resp_id_q;
   assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
   assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;

endmodule
